// File: rtl/keypad_scanner_if.sv
// Keypad scanner port bundle: keypad columns in, row drive and decoded key events out.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] r_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  col,
    output r_sel,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output col,
    input  r_sel,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce and one hex code per press.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  keypad_scanner_if.master  kp
);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 3 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_s;
  logic [1:0]       r_state;
  logic [1:0]       r_row;
  logic [DIV_W-1:0] r_div;
  logic [DEB_W-1:0] r_cnt;
  logic [3:0]       r_col_lat;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;
  logic [3:0]       w_low;
  logic             w_single;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_key;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] r_rep;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col_meta <= 4'hF;
      r_col_s    <= 4'hF;
    end else begin
      r_col_meta <= kp.col;
      r_col_s    <= r_col_meta;
    end
  end

  // A valid press pulls exactly one column low; ghosting/multi-key patterns are skipped.
  assign w_low    = ~r_col_s;
  assign w_single = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);

  always_comb begin
    w_col_idx = 2'd0;
    case (r_col_lat)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_key = 4'h0;
    case ({r_row, w_col_idx})
      4'd0:  w_key = 4'h1;
      4'd1:  w_key = 4'h2;
      4'd2:  w_key = 4'h3;
      4'd3:  w_key = 4'hA;
      4'd4:  w_key = 4'h4;
      4'd5:  w_key = 4'h5;
      4'd6:  w_key = 4'h6;
      4'd7:  w_key = 4'hB;
      4'd8:  w_key = 4'h7;
      4'd9:  w_key = 4'h8;
      4'd10: w_key = 4'h9;
      4'd11: w_key = 4'hC;
      4'd12: w_key = 4'hE;
      4'd13: w_key = 4'h0;
      4'd14: w_key = 4'hF;
      default: w_key = 4'hD;
    endcase
  end

  // The row index doubles as the frozen row drive while a key is being tracked.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= SCAN;
      r_row       <= 2'd0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_col_lat   <= 4'hF;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (w_single) begin
              r_col_lat <= r_col_s;
              r_cnt     <= '0;
              r_state   <= DEBOUNCE;
            end else begin
              r_row <= r_row + 2'd1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (r_col_s == r_col_lat) begin
            if (r_cnt == DEB_LAST) begin
              r_cnt       <= '0;
              r_key_code  <= w_key;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
              r_state     <= HELD;
`ifdef KEY_REPEAT_EN
              r_rep       <= '0;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt   <= '0;
            r_row   <= r_row + 2'd1;
            r_div   <= '0;
            r_state <= SCAN;
          end
        end
        HELD: begin
          // The first all-released cycle already counts toward the release debounce.
          if (r_col_s == 4'hF) begin
            r_cnt   <= DEB_W'(1);
            r_state <= RELEASE;
          end
`ifdef KEY_REPEAT_EN
          else if (r_rep == REP_LAST) begin
            r_rep       <= '0;
            r_key_valid <= 1'b1;
          end else begin
            r_rep <= r_rep + 1'b1;
          end
`endif
        end
        default: begin
          if (r_col_s == 4'hF) begin
            if (r_cnt == DEB_LAST) begin
              r_cnt      <= '0;
              r_key_held <= 1'b0;
              r_row      <= 2'd0;
              r_div      <= '0;
              r_state    <= SCAN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= HELD;
`ifdef KEY_REPEAT_EN
            r_rep   <= '0;
`endif
          end
        end
      endcase
    end
  end

  assign kp.r_sel     = ~(4'b0001 << r_row);
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner; cycle numbers count rising edges
// since the last reset release, with all drives and checks made 1 time unit after the edge.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   validCount = 0;
  int   doubleValid = 0;
  logic prevValid = 1'b0;
  int   baseValid;

`ifdef KEY_REPEAT_EN
  localparam int EXP_PULSES = 4;
`else
  localparam int EXP_PULSES = 1;
`endif

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES(64)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .kp(kp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kp.key_valid) begin
      validCount = validCount + 1;
      if (prevValid) doubleValid = doubleValid + 1;
    end
    prevValid = kp.key_valid;
  end

  task automatic applyStimulus(input logic [3:0] c);
    kp.col = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(4'hF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    kp.col = 4'hF;
    #2;
    resetDut();

    // Idle scan rotation
    checkOutput("rst_rsel", kp.r_sel, 4'b1110);
    checkOutput("rst_valid", kp.key_valid, 1'b0);
    checkOutput("rst_held", kp.key_held, 1'b0);
    checkOutput("rst_code", kp.key_code, 4'h0);
    waitUntil(4);
    checkOutput("scan_row1", kp.r_sel, 4'b1101);
    waitUntil(8);
    checkOutput("scan_row2", kp.r_sel, 4'b1011);
    waitUntil(12);
    checkOutput("scan_row3", kp.r_sel, 4'b0111);
    waitUntil(16);
    checkOutput("scan_wrap", kp.r_sel, 4'b1110);
    checkOutput("idle_no_valid", validCount, 0);

    // Key 4 on row1, then clean release
    waitUntil(20);
    applyStimulus(4'b1110);
    waitUntil(31);
    checkOutput("k4_pre_valid", kp.key_valid, 1'b0);
    waitUntil(32);
    checkOutput("k4_valid", kp.key_valid, 1'b1);
    checkOutput("k4_code", kp.key_code, 4'h4);
    checkOutput("k4_held", kp.key_held, 1'b1);
    checkOutput("k4_frozen", kp.r_sel, 4'b1101);
    waitUntil(33);
    checkOutput("k4_pulse_1cyc", kp.key_valid, 1'b0);
    waitUntil(220);
    applyStimulus(4'hF);
    waitUntil(229);
    checkOutput("k4_held_late", kp.key_held, 1'b1);
    waitUntil(230);
    checkOutput("k4_released", kp.key_held, 1'b0);
    checkOutput("k4_rescan", kp.r_sel, 4'b1110);
    checkOutput("k4_one_pulse", validCount, 1);

    // Short glitch on row3 aborts debounce and wraps to row0
    waitUntil(242);
    applyStimulus(4'b0111);
    waitUntil(245);
    applyStimulus(4'hF);
    waitUntil(247);
    checkOutput("glitch_frozen", kp.r_sel, 4'b0111);
    waitUntil(248);
    checkOutput("glitch_wrap", kp.r_sel, 4'b1110);
    waitUntil(252);
    checkOutput("glitch_resume", kp.r_sel, 4'b1101);
    checkOutput("glitch_no_valid", validCount, 1);

    // Key 3 on row0 with a release bounce
    waitUntil(264);
    applyStimulus(4'b1011);
    waitUntil(276);
    checkOutput("k3_valid", kp.key_valid, 1'b1);
    checkOutput("k3_code", kp.key_code, 4'h3);
    waitUntil(290);
    applyStimulus(4'hF);
    waitUntil(294);
    applyStimulus(4'b1011);
    waitUntil(296);
    checkOutput("k3_bounce_held", kp.key_held, 1'b1);
    waitUntil(300);
    checkOutput("k3_still_held", kp.key_held, 1'b1);
    checkOutput("k3_frozen", kp.r_sel, 4'b1110);
    checkOutput("k3_one_pulse", validCount, 2);
    applyStimulus(4'hF);
    waitUntil(309);
    checkOutput("k3_held_late", kp.key_held, 1'b1);
    waitUntil(310);
    checkOutput("k3_released", kp.key_held, 1'b0);

    // Reset during debounce of key 1
    applyStimulus(4'b1110);
    waitUntil(318);
    checkOutput("abort_frozen", kp.r_sel, 4'b1110);
    checkOutput("abort_code_kept", kp.key_code, 4'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_rsel", kp.r_sel, 4'b1110);
    checkOutput("abort_code", kp.key_code, 4'h0);
    checkOutput("abort_held", kp.key_held, 1'b0);
    checkOutput("abort_valid", kp.key_valid, 1'b0);
    resetDut();
    baseValid = validCount;
    checkOutput("abort_no_pulse", baseValid, 2);

    // Two keys in one row are ignored
    applyStimulus(4'b1100);
    waitUntil(4);
    checkOutput("multi_rot1", kp.r_sel, 4'b1101);
    waitUntil(100);
    checkOutput("multi_rot2", kp.r_sel, 4'b1101);
    checkOutput("multi_no_valid", validCount, baseValid);
    applyStimulus(4'hF);

    // Key 0 on row3 held 200 cycles after accept
    waitUntil(108);
    applyStimulus(4'b1101);
    waitUntil(120);
    checkOutput("k0_valid", kp.key_valid, 1'b1);
    checkOutput("k0_code", kp.key_code, 4'h0);
    checkOutput("k0_held", kp.key_held, 1'b1);
    checkOutput("k0_frozen", kp.r_sel, 4'b0111);
`ifdef KEY_REPEAT_EN
    waitUntil(184);
    checkOutput("k0_repeat1", kp.key_valid, 1'b1);
    checkOutput("k0_repeat_code", kp.key_code, 4'h0);
`endif
    waitUntil(315);
    checkOutput("k0_pulses", validCount - baseValid, EXP_PULSES);
    waitUntil(320);
    applyStimulus(4'hF);
    waitUntil(329);
    checkOutput("k0_held_late", kp.key_held, 1'b1);
    waitUntil(330);
    checkOutput("k0_released", kp.key_held, 1'b0);
    checkOutput("k0_rescan", kp.r_sel, 4'b1110);
    checkOutput("no_double_valid", doubleValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
